sbus_to_ahbl: RTL and testbench
===============================

# sbus_to_ahbl

Bridges a Hazard3-style SBUS valid/ready initiator (for example a debug System Bus Access (SBA) requester or a DMA-style agent) onto an AHB-Lite manager port. Each accepted SBUS request becomes exactly one single-beat AHB-Lite transfer, with a registered response back to SBUS. It sits in front of the system interconnect in the opposite direction to the APU's AHB-to-SBUS slave bridge, so SBUS-native agents can reach any AHB subordinate.

## Interface
Parameters:
- `W_ADDR`, default 32: address width on both sides.
- `HPROT_VAL`, default 4'h3: constant driven on `hprot` (data access, privileged).

Ports:
- `clk` in, 1: sole clock.
- `rst` in, 1: reset, synchronous, active-high.
- `sbus_addr` in, W_ADDR: request address.
- `sbus_write` in, 1: 1 = write.
- `sbus_size` in, 2: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `sbus_vld` in, 1: request valid; the requester holds it and its payload stable until `sbus_rdy`.
- `sbus_wdata` in, 32: write data, sampled at request acceptance.
- `sbus_rdy` out, 1: one-cycle response strobe.
- `sbus_err` out, 1: error qualifier, valid only when `sbus_rdy` is high.
- `sbus_rdata` out, 32: read data, valid when `sbus_rdy` is high on a read.
- `haddr` out, W_ADDR: AHB address.
- `hwrite` out, 1: AHB write.
- `htrans` out, 2: AHB transfer type; only IDLE (0) and NONSEQ (2) are used.
- `hsize` out, 3: AHB size, equal to {1'b0, sbus_size}.
- `hburst` out, 3: constant 0 (SINGLE).
- `hprot` out, 4: constant HPROT_VAL.
- `hmastlock` out, 1: constant 0.
- `hready` in, 1: AHB bus ready.
- `hresp` in, 1: AHB error response.
- `hwdata` out, 32: AHB write data.
- `hrdata` in, 32: AHB read data.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE:**
  - If `sbus_vld` is high and the request is legal:
    - register addr, write, size and wdata;
    - drive `htrans`=NONSEQ;
    - go to ADDR.
  - If `sbus_vld` is high and the request is illegal: go to RESP with err=1. No AHB transfer is issued.
  - A request is illegal when size=3, or size=1 with addr[0]=1, or size=2 with addr[1:0]≠0.
- **ADDR:** hold the NONSEQ address phase until `hready`=1. Then:
  - drive `htrans`=IDLE;
  - drive `hwdata` from the registered wdata;
  - go to DATA.
- **DATA:** wait for `hready`=1. Then:
  - capture `hrdata` (reads only);
  - set err=`hresp`;
  - go to RESP.
  - The first cycle of an AHB error response (`hready`=0, `hresp`=1) is simply waited through. `htrans` is already IDLE, so no cancel is needed.
- **RESP:** `sbus_rdy`=1 for exactly one cycle, with `sbus_err` and `sbus_rdata` valid. Then go to IDLE.
- `sbus_vld` is ignored while in RESP. A new request may be presented from the cycle after `sbus_rdy`.
- `sbus_rdata` holds its last value outside RESP. On writes and errors it is unchanged.
- Byte lanes are not replicated: `hwdata` is passed through exactly as supplied by SBUS.

## Timing
- All outputs are registered.
- Reset values: `htrans`=0, `haddr`=0, `hwrite`=0, `hsize`=0, `hwdata`=0, `sbus_rdy`=0, `sbus_err`=0, `sbus_rdata`=0. `hburst`/`hprot`/`hmastlock` are constants.
- Zero-wait-state access, with `sbus_vld` first seen in IDLE at cycle N:
  - cycle N+1: address phase;
  - cycle N+2: data phase;
  - cycle N+3: `sbus_rdy`.
- Each AHB wait state adds exactly one cycle, whether in the address phase (`hready` low from the previous master's data phase) or in the data phase.
- Illegal request seen at cycle N: `sbus_rdy`=1 and `sbus_err`=1 at N+1.
- Back-to-back: with `sbus_vld` held continuously, a new request is accepted in the cycle after the RESP cycle. Zero-wait throughput is one transfer per 4 cycles.
- Synchronous reset mid-transfer: the next edge forces IDLE with all outputs at reset values, and no `sbus_rdy` is generated. This is acceptable only under a system-wide reset.
- AHB error: `sbus_rdy`+`sbus_err` appear one cycle after the second (`hready`=1) error cycle.

## Structure
- Shared package `ahbl_pkg`:
  - HTRANS_IDLE/HTRANS_NONSEQ;
  - HSIZE_BYTE/HALF/WORD;
  - the SBUS size encoding.
- The FSM state enum is local to the block.
- Single flat module with no sub-module. The alignment check is a small local function.

## Test plan
- **Word read, zero wait:** vld with addr=0x1000, size=2, hrdata=0xDEADBEEF → NONSEQ at N+1, `sbus_rdy` at N+3 with rdata=0xDEADBEEF, err=0.
- **Byte write with 2 data wait states:** addr=0x2003, size=0, wdata=0x000000A5 → hsize=0, hwdata=0x000000A5 held for the whole data phase, `sbus_rdy` at N+5.
- **AHB error:** two-cycle ERROR response on a read → `htrans` IDLE throughout, `sbus_rdy`=1 with `sbus_err`=1, rdata unchanged.
- **Misaligned:** size=2 at addr=0x1002, and separately size=3 → no NONSEQ ever, `sbus_rdy`+`sbus_err` at N+1.
- **Back-to-back:** three reads with vld held → exactly three NONSEQs, spaced 4 cycles apart.
- **Reset:** `rst` asserted in the DATA state → next cycle `htrans`=0 and `sbus_rdy`=0; after release the next request completes normally.

Source files
------------

// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - shared AHB-Lite and SBUS encodings
package ahbl_pkg;

  // AHB-Lite transfer types (only the two used by single-beat managers)
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // AHB-Lite transfer sizes
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // SBUS size encoding; 3 is reserved and always rejected
  localparam logic [1:0] SBUS_SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SBUS_SIZE_HALF    = 2'd1;
  localparam logic [1:0] SBUS_SIZE_WORD    = 2'd2;
  localparam logic [1:0] SBUS_SIZE_ILLEGAL = 2'd3;

endpackage

// File: rtl/sbus_to_ahbl.sv
// rtl/sbus_to_ahbl.sv - SBUS valid/ready initiator to single-beat AHB-Lite manager
module sbus_to_ahbl
  import ahbl_pkg::*;
#(
  parameter int         W_ADDR    = 32,
  parameter logic [3:0] HPROT_VAL = 4'h3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_ADDR-1:0] sbus_addr,
  input  logic              sbus_write,
  input  logic [1:0]        sbus_size,
  input  logic              sbus_vld,
  input  logic [31:0]       sbus_wdata,
  output logic              sbus_rdy,
  output logic              sbus_err,
  output logic [31:0]       sbus_rdata,
  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  input  logic              hready,
  input  logic              hresp,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_e;

  // Natural alignment: halfwords on even addresses, words on 4-byte boundaries
  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SBUS_SIZE_BYTE:    return 1'b1;
      SBUS_SIZE_HALF:    return ~addr_lo[0];
      SBUS_SIZE_WORD:    return addr_lo == 2'b00;
      SBUS_SIZE_ILLEGAL: return 1'b0;
      default:           return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] to_hsize(input logic [1:0] size);
    case (size)
      SBUS_SIZE_BYTE: return HSIZE_BYTE;
      SBUS_SIZE_HALF: return HSIZE_HALF;
      default:        return HSIZE_WORD;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [W_ADDR-1:0]   haddr_q, haddr_d;
  logic                hwrite_q, hwrite_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [1:0]          htrans_q, htrans_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         hwdata_q, hwdata_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  // Next-state and registered-output logic for the transfer sequencer
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    htrans_d = htrans_q;
    wdata_d  = wdata_q;
    hwdata_d = hwdata_q;
    rdy_d    = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (sbus_vld) begin
          if (req_legal(sbus_size, sbus_addr[1:0])) begin
            haddr_d  = sbus_addr;
            hwrite_d = sbus_write;
            hsize_d  = to_hsize(sbus_size);
            wdata_d  = sbus_wdata;
            htrans_d = HTRANS_NONSEQ;
            state_d  = ST_ADDR;
          end else begin
            // Rejected before touching the bus; answer on the next cycle
            rdy_d   = 1'b1;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_ADDR: begin
        if (hready) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        // First ERROR cycle has hready low and is simply waited through
        if (hready) begin
          if (!hwrite_q && !hresp) begin
            rdata_d = hrdata;
          end
          err_d   = hresp;
          rdy_d   = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b000;
      htrans_q <= HTRANS_IDLE;
      wdata_q  <= 32'h0;
      hwdata_q <= 32'h0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      htrans_q <= htrans_d;
      wdata_q  <= wdata_d;
      hwdata_q <= hwdata_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign haddr      = haddr_q;
  assign hwrite     = hwrite_q;
  assign hsize      = hsize_q;
  assign htrans     = htrans_q;
  assign hwdata     = hwdata_q;
  assign hburst     = 3'b000;
  assign hprot      = HPROT_VAL;
  assign hmastlock  = 1'b0;
  assign sbus_rdy   = rdy_q;
  assign sbus_err   = err_q;
  assign sbus_rdata = rdata_q;

endmodule

// File: tb/tb_sbus_to_ahbl.sv
// tb/tb_sbus_to_ahbl.sv - scoreboard bench for sbus_to_ahbl
module tb_sbus_to_ahbl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sbus_addr = '0;
  logic        sbus_write = 1'b0;
  logic [1:0]  sbus_size = '0;
  logic        sbus_vld = 1'b0;
  logic [31:0] sbus_wdata = '0;
  logic        sbus_rdy, sbus_err;
  logic [31:0] sbus_rdata;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hwdata;
  logic [31:0] hrdata = '0;

  sbus_to_ahbl dut (
    .clk(clk), .rst(rst),
    .sbus_addr(sbus_addr), .sbus_write(sbus_write), .sbus_size(sbus_size),
    .sbus_vld(sbus_vld), .sbus_wdata(sbus_wdata),
    .sbus_rdy(sbus_rdy), .sbus_err(sbus_err), .sbus_rdata(sbus_rdata),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hready(hready), .hresp(hresp), .hwdata(hwdata), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cycle;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  hsize;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    logic        err;
    logic [31:0] rd;
  } xfer_t;

  resp_t sq[$];
  xfer_t aq[$];
  int    ns_cycles[$];
  logic [31:0] model_rdata = 32'h0;

  // Response monitor: every sbus_rdy must match the oldest expected response
  always @(negedge clk) begin
    if (sbus_rdy) begin
      if (sq.size() == 0) begin
        chk("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = sq.pop_front();
        chk("rdy_cycle", cyc, e.cycle);
        chk("rdy_err", {31'd0, sbus_err}, {31'd0, e.err});
        chk("rdy_rdata", sbus_rdata, e.rdata);
      end
    end
  end

  // AHB subordinate model: drives hready/hresp/hrdata for the coming edge
  bit    addr_active = 0;
  bit    data_pending = 0;
  bit    efirst = 0;
  int    aw_left = 0;
  int    dleft = 0;
  xfer_t cur;
  always @(negedge clk) begin
    if (rst) begin
      addr_active  = 0;
      data_pending = 0;
      hready = 1'b1;
      hresp  = 1'b0;
    end else if (data_pending) begin
      chk("dphase_htrans_idle", {30'd0, htrans}, 32'd0);
      if (cur.write) chk("dphase_hwdata", hwdata, cur.wdata);
      hrdata = $urandom;
      if (dleft > 0) begin
        hready = 1'b0; hresp = 1'b0; dleft--;
      end else if (cur.err && !efirst) begin
        hready = 1'b0; hresp = 1'b1; efirst = 1;
      end else begin
        hready = 1'b1; hresp = cur.err;
        if (!cur.err) hrdata = cur.rd;
        data_pending = 0;
      end
    end else if (htrans == 2'b10) begin
      if (!addr_active) begin
        ns_cycles.push_back(cyc);
        if (aq.size() == 0) begin
          chk("nonseq_unexpected", 32'd1, 32'd0);
          cur = '{addr: 0, write: 0, hsize: 0, wdata: 0, aw: 0, dw: 0, err: 0, rd: 0};
        end else begin
          cur = aq.pop_front();
          chk("aphase_haddr", haddr, cur.addr);
          chk("aphase_hwrite", {31'd0, hwrite}, {31'd0, cur.write});
          chk("aphase_hsize", {29'd0, hsize}, {29'd0, cur.hsize});
        end
        addr_active = 1;
        aw_left = cur.aw;
      end
      hresp = 1'b0;
      hrdata = $urandom;
      if (aw_left > 0) begin
        hready = 1'b0; aw_left--;
      end else begin
        hready = 1'b1;
        addr_active = 0;
        data_pending = 1;
        dleft = cur.dw;
        efirst = 0;
      end
    end else begin
      hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
    end
  end

  function automatic bit legal(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 0;
    if (size == 2'd1 && (addr % 2) != 0) return 0;
    if (size == 2'd2 && (addr % 4) != 0) return 0;
    return 1;
  endfunction

  // Called at a negedge; returns at the negedge after sbus_rdy with vld still high
  task automatic do_req(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                        input logic [31:0] wdata, input int aw, input int dw,
                        input logic err, input logic [31:0] rd);
    int n;
    int waited;
    resp_t r;
    n = cyc;
    sbus_vld = 1'b1; sbus_addr = addr; sbus_write = wr;
    sbus_size = size; sbus_wdata = wdata;
    if (legal(addr, size)) begin
      aq.push_back('{addr: addr, write: wr, hsize: {1'b0, size}, wdata: wdata,
                     aw: aw, dw: dw, err: err, rd: rd});
      if (!wr && !err) model_rdata = rd;
      r.err = err; r.rdata = model_rdata; r.cycle = n + 3 + aw + dw + (err ? 1 : 0);
    end else begin
      r.err = 1'b1; r.rdata = model_rdata; r.cycle = n + 1;
    end
    sq.push_back(r);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!sbus_rdy && waited < 100);
    if (!sbus_rdy) chk("rdy_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    sbus_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rdy", {31'd0, sbus_rdy}, 32'd0);
    chk("rst_err", {31'd0, sbus_err}, 32'd0);
    chk("rst_rdata", sbus_rdata, 32'd0);
    chk("const_hburst", {29'd0, hburst}, 32'd0);
    chk("const_hprot", {28'd0, hprot}, 32'd3);
    chk("const_hmastlock", {31'd0, hmastlock}, 32'd0);
    rst = 1'b0;
    idle(1);

    do_req(32'h1000, 0, 2, 32'h0, 0, 0, 0, 32'hDEADBEEF);
    idle(1);
    do_req(32'h2003, 1, 0, 32'h000000A5, 0, 2, 0, 32'h0);
    idle(1);
    do_req(32'h3000, 0, 2, 32'h0, 0, 0, 1, 32'h12345678);
    idle(1);
    do_req(32'h4000, 0, 1, 32'h0, 2, 1, 0, 32'hCAFE0000);
    idle(1);

    ns_cycles.delete();
    do_req(32'h1002, 0, 2, 32'h0, 0, 0, 0, 32'h0);
    idle(1);
    do_req(32'h1000, 1, 3, 32'h55, 0, 0, 0, 32'h0);
    idle(2);
    chk("illegal_no_nonseq", ns_cycles.size(), 32'd0);

    ns_cycles.delete();
    do_req(32'h5000, 0, 2, 32'h0, 0, 0, 0, 32'h11111111);
    do_req(32'h5004, 0, 2, 32'h0, 0, 0, 0, 32'h22222222);
    do_req(32'h5008, 0, 2, 32'h0, 0, 0, 0, 32'h33333333);
    idle(2);
    chk("b2b_count", ns_cycles.size(), 32'd3);
    if (ns_cycles.size() == 3) begin
      chk("b2b_gap1", ns_cycles[1] - ns_cycles[0], 32'd4);
      chk("b2b_gap2", ns_cycles[2] - ns_cycles[1], 32'd4);
    end

    // Reset while in the data phase of a read with long waits
    sbus_vld = 1'b1; sbus_addr = 32'h6000; sbus_write = 1'b0; sbus_size = 2'd2;
    aq.push_back('{addr: 32'h6000, write: 1'b0, hsize: 3'd2, wdata: 32'h0,
                   aw: 0, dw: 5, err: 1'b0, rd: 32'h0});
    @(negedge clk);
    sbus_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_htrans", {30'd0, htrans}, 32'd0);
    chk("midrst_rdy", {31'd0, sbus_rdy}, 32'd0);
    chk("midrst_rdata", sbus_rdata, 32'd0);
    model_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    do_req(32'h7000, 0, 2, 32'h0, 1, 1, 0, 32'hA5A5F00D);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [1:0]  s;
      a = $urandom;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      do_req(a, 1'($urandom), s, $urandom, $urandom_range(0, 2),
             $urandom_range(0, 2), ($urandom_range(0, 7) == 0), $urandom);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("sb_drain", sq.size(), 32'd0);
    chk("aq_drain", aq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
